// File: rtl/lsu_ctrl_if.sv
// Data-memory request/acknowledge port between the load/store sequencer
// (master) and the data memory (slave).
interface lsu_ctrl_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store sequencer: byte enables, store lane replication, load extension.
// Optional access timeout with bus_fault is enabled by defining LSU_TIMEOUT_EN.
//
// state    | meaning
// S_IDLE   | waiting for mem_read/mem_write; aligned op latched, misaligned op rejected
// S_ACCESS | mem_req held with stable outputs until mem_ack (or timeout)
// S_DONE   | one retire cycle, stall released, strobes ignored
module lsu_ctrl #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  func3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        misaligned,
   output logic        bus_fault,
   lsu_ctrl_if.master  mem
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t      state;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;

   logic        op;
   logic        size_b;
   logic        size_h;
   logic        mis;
   logic [3:0]  be_n;
   logic [31:0] wdata_n;
   logic [31:0] rd_byte_sh;
   logic [31:0] rd_half_sh;
   logic [31:0] fmt;

   // Undefined func3 encodings fall through to word size.
   always_comb begin
      op      = mem_write | mem_read;
      size_b  = (func3[1:0] == 2'b00);
      size_h  = (func3[1:0] == 2'b01);
      mis     = 1'b0;
      be_n    = 4'hF;
      wdata_n = store_data;
      if (size_b) begin
         be_n    = 4'b0001 << addr[1:0];
         wdata_n = {4{store_data[7:0]}};
      end else if (size_h) begin
         mis     = addr[0];
         be_n    = 4'b0011 << {addr[1], 1'b0};
         wdata_n = {2{store_data[15:0]}};
      end else begin
         mis     = (addr[1:0] != 2'b00);
      end
   end

   always_comb begin
      rd_byte_sh = mem.mem_rdata >> {off_q, 3'b000};
      rd_half_sh = mem.mem_rdata >> {off_q[1], 4'b0000};
      fmt        = mem.mem_rdata;
      if (f3_q[1:0] == 2'b00)
         fmt = f3_q[2] ? {24'b0, rd_byte_sh[7:0]} : {{24{rd_byte_sh[7]}}, rd_byte_sh[7:0]};
      else if (f3_q[1:0] == 2'b01)
         fmt = f3_q[2] ? {16'b0, rd_half_sh[15:0]} : {{16{rd_half_sh[15]}}, rd_half_sh[15:0]};
   end

   assign stall = ((state == S_IDLE) && op) || (state == S_ACCESS);

`ifdef LSU_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt;
   logic          fault_q;
   assign bus_fault = fault_q;
`else
   assign bus_fault = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         f3_q          <= '0;
         off_q         <= '0;
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_be    <= '0;
         mem.mem_wdata <= '0;
         load_data     <= '0;
         load_valid    <= 1'b0;
         misaligned    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         cnt           <= '0;
         fault_q       <= 1'b0;
`endif
      end else begin
         load_valid <= 1'b0;
         misaligned <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         fault_q    <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (op && mis) begin
                  state      <= S_DONE;
                  misaligned <= 1'b1;
                  load_data  <= '0;
                  load_valid <= ~mem_write;
               end else if (op) begin
                  state         <= S_ACCESS;
                  mem.mem_req   <= 1'b1;
                  mem.mem_we    <= mem_write;
                  mem.mem_addr  <= {addr[31:2], 2'b00};
                  mem.mem_be    <= be_n;
                  mem.mem_wdata <= wdata_n;
                  f3_q          <= func3;
                  off_q         <= addr[1:0];
`ifdef LSU_TIMEOUT_EN
                  cnt           <= CW'(TIMEOUT_CYCLES - 1);
`endif
               end
            end
            S_ACCESS: begin
               // An ack on the terminal-count cycle still completes normally.
               if (mem.mem_ack) begin
                  state       <= S_DONE;
                  mem.mem_req <= 1'b0;
                  if (!mem.mem_we) begin
                     load_data  <= fmt;
                     load_valid <= 1'b1;
                  end
               end
`ifdef LSU_TIMEOUT_EN
               else if (cnt == '0) begin
                  state       <= S_DONE;
                  mem.mem_req <= 1'b0;
                  fault_q     <= 1'b1;
                  load_data   <= '0;
                  load_valid  <= ~mem.mem_we;
               end else begin
                  cnt <= cnt - CW'(1);
               end
`endif
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl against a size/offset arithmetic reference model.
module tb_lsu_ctrl;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_read, mem_write;
   logic [2:0]  func3;
   logic [31:0] addr, store_data;
   logic        stall, load_valid, misaligned, bus_fault;
   logic [31:0] load_data;
   int          errors = 0;
   int          checks = 0;

   lsu_ctrl_if mif();

   lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .func3      (func3),
      .addr       (addr),
      .store_data (store_data),
      .stall      (stall),
      .load_data  (load_data),
      .load_valid (load_valid),
      .misaligned (misaligned),
      .bus_fault  (bus_fault),
      .mem        (mif.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Drives one instruction from IDLE and follows it to the next IDLE.
   // delay = ACCESS cycle on which memory acks.
   task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rdata, input int delay);
      logic        op, is_w, mis, fault;
      int          sz, n_acc;
      logic [1:0]  off;
      logic [3:0]  be;
      logic [31:0] wd, ld, sh;
      logic [7:0]  b8;
      logic [15:0] h16;

      op   = rd | wr;
      is_w = wr;
      off  = a[1:0];
      sz   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      mis  = (sz == 2 && a[0]) || (sz == 4 && off != 2'b00);
      be   = (sz == 1) ? (4'b0001 << off) : (sz == 2) ? (4'b0011 << (off & 2'b10)) : 4'hF;
      wd   = (sz == 1) ? {4{sd[7:0]}} : (sz == 2) ? {2{sd[15:0]}} : sd;
      sh   = rdata >> (8 * off);
      b8   = sh[7:0];
      h16  = sh[15:0];
      if (sz == 1)      ld = f3[2] ? {24'b0, b8} : {{24{b8[7]}}, b8};
      else if (sz == 2) ld = f3[2] ? {16'b0, h16} : {{16{h16[15]}}, h16};
      else              ld = rdata;
`ifdef LSU_TIMEOUT_EN
      fault = (delay > TO);
`else
      fault = 1'b0;
`endif
      n_acc = fault ? TO : delay;

      mem_read = rd; mem_write = wr; func3 = f3; addr = a; store_data = sd;
      #1;
      chk("stall_idle", 32'(stall), 32'(op));
      if (!op) begin
         @(posedge clk); #1;
         chk("noop_req", 32'(mif.mem_req), 32'd0);
         return;
      end
      @(posedge clk); #1;
      if (mis) begin
         chk("mis_pulse", 32'(misaligned), 32'd1);
         chk("mis_req", 32'(mif.mem_req), 32'd0);
         chk("mis_stall", 32'(stall), 32'd0);
         chk("mis_ldata", load_data, 32'd0);
         chk("mis_lvalid", 32'(load_valid), 32'(!is_w));
         mem_read = 1'b0; mem_write = 1'b0;
         @(posedge clk); #1;
         chk("mis_after", 32'(misaligned), 32'd0);
         return;
      end
      addr = $urandom; store_data = $urandom;
      for (int i = 1; i <= n_acc; i++) begin
         chk("acc_stall", 32'(stall), 32'd1);
         chk("acc_req", 32'(mif.mem_req), 32'd1);
         chk("acc_we", 32'(mif.mem_we), 32'(is_w));
         chk("acc_addr", mif.mem_addr, {a[31:2], 2'b00});
         chk("acc_be", 32'(mif.mem_be), 32'(be));
         if (is_w) chk("acc_wdata", mif.mem_wdata, wd);
         mif.mem_ack   = (i == delay);
         mif.mem_rdata = (i == delay) ? rdata : $urandom;
         @(posedge clk); #1;
         mif.mem_ack = 1'b0;
      end
      chk("done_stall", 32'(stall), 32'd0);
      chk("done_req", 32'(mif.mem_req), 32'd0);
      chk("done_lvalid", 32'(load_valid), 32'(!is_w));
      chk("done_fault", 32'(bus_fault), 32'(fault));
      chk("done_mis", 32'(misaligned), 32'd0);
      if (!is_w) chk("done_ldata", load_data, fault ? 32'd0 : ld);
      mem_read = 1'b0; mem_write = 1'b0;
      mif.mem_ack = 1'($urandom);
      @(posedge clk); #1;
      mif.mem_ack = 1'b0;
      chk("back_idle_req", 32'(mif.mem_req), 32'd0);
      chk("back_idle_lv", 32'(load_valid), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; func3 = 3'b0;
      addr = '0; store_data = '0; mif.mem_ack = 1'b0; mif.mem_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", 32'(mif.mem_req), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_be", 32'(mif.mem_be), 32'd0);
      chk("rst_addr", mif.mem_addr, 32'd0);
      chk("rst_ldata", load_data, 32'd0);
      chk("rst_lvalid", 32'(load_valid), 32'd0);
      chk("rst_fault", 32'(bus_fault), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases
      run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3);
      run_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 1);
      run_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 2);
      run_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 2);
      run_op(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1);
      run_op(1'b1, 1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 1);
      run_op(1'b1, 1'b0, 3'b101, 32'h402, 32'h0, 32'h8001_7FFF, 1);
      run_op(1'b1, 1'b0, 3'b111, 32'h404, 32'h0, 32'h1357_9BDF, 1);
      run_op(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h1111_2222, TO);
      run_op(1'b1, 1'b0, 3'b010, 32'h504, 32'h0, 32'h3333_4444, TO + 2);

      // Stray ack while idle must not start anything
      mif.mem_ack = 1'b1;
      @(posedge clk); #1;
      mif.mem_ack = 1'b0;
      chk("stray_ack_req", 32'(mif.mem_req), 32'd0);
      chk("stray_ack_lv", 32'(load_valid), 32'd0);

      // Reset while in ACCESS abandons the request
      mem_read = 1'b1; func3 = 3'b010; addr = 32'h600;
      @(posedge clk); #1;
      chk("midrst_req_on", 32'(mif.mem_req), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0; mem_read = 1'b0;
      @(posedge clk); #1;
      chk("midrst_req_off", 32'(mif.mem_req), 32'd0);
      chk("midrst_stall", 32'(stall), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midrst_idle", 32'(mif.mem_req), 32'd0);
      run_op(1'b1, 1'b0, 3'b000, 32'h601, 32'h0, 32'h0000_7F00, 1);

      // Randomized traffic
      for (int k = 0; k < 200; k++) begin
         logic [1:0] kind;
         kind = 2'($urandom_range(0, 3));
         run_op(kind[0] | (kind == 2'b00 && $urandom_range(0, 3) == 0),
                kind[1], 3'($urandom), $urandom, $urandom, $urandom,
                $urandom_range(1, TO + 2));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
